// File: rtl/iter_affine_cpu.sv
// Multi-pass affine controller: runs ADD -> MUL -> SUB per pass on a latched sample and coefficients.
// Build option: define ITER_AFFINE_SAT_EN to saturate overflowing steps; otherwise they wrap.
module iter_affine_cpu #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int K_W    = 8,
    parameter int ITER_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   x_in,
    input  logic signed [K_W-1:0]    add_k,
    input  logic signed [K_W-1:0]    mul_k,
    input  logic signed [K_W-1:0]    sub_k,
    input  logic        [ITER_W-1:0] iter_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  y_out,
    output logic                     ovf
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_MUL  = 3'd2,
        S_SUB  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam int EXT_W = OUT_W + K_W + 1;

    state_t                   state;
    state_t                   state_next;
    logic signed [OUT_W-1:0]  acc;
    logic signed [K_W-1:0]    add_q;
    logic signed [K_W-1:0]    mul_q;
    logic signed [K_W-1:0]    sub_q;
    logic        [ITER_W-1:0] remaining;
    logic signed [EXT_W-1:0]  acc_x;
    logic signed [EXT_W-1:0]  wide;
    logic signed [OUT_W-1:0]  step_val;
    logic                     step_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:  state_next = in_valid ? S_ADD : S_IDLE;
            S_ADD:   state_next = S_MUL;
            S_MUL:   state_next = S_SUB;
            S_SUB:   state_next = (remaining != '0) ? S_ADD : S_HOLD;
            S_HOLD:  state_next = out_ready ? S_IDLE : S_HOLD;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_HOLD);
    end

    // One shared wide datapath; the product of OUT_W and K_W operands always fits EXT_W exactly.
    always_comb begin
        acc_x = EXT_W'(acc);
        case (state)
            S_ADD:   wide = acc_x + EXT_W'(add_q);
            S_MUL:   wide = acc_x * EXT_W'(mul_q);
            S_SUB:   wide = acc_x - EXT_W'(sub_q);
            default: wide = acc_x;
        endcase
    end

    always_comb begin
        step_ovf = (wide[EXT_W-1:OUT_W-1] != {(EXT_W-OUT_W+1){wide[OUT_W-1]}});
`ifdef ITER_AFFINE_SAT_EN
        if (step_ovf) begin
            step_val = wide[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            step_val = wide[OUT_W-1:0];
        end
`else
        step_val = wide[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            add_q     <= '0;
            mul_q     <= '0;
            sub_q     <= '0;
            remaining <= '0;
            y_out     <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        acc       <= OUT_W'(x_in);
                        add_q     <= add_k;
                        mul_q     <= mul_k;
                        sub_q     <= sub_k;
                        remaining <= iter_in;
                        ovf       <= 1'b0;
                    end
                end
                S_ADD, S_MUL: begin
                    acc <= step_val;
                    ovf <= ovf | step_ovf;
                end
                S_SUB: begin
                    ovf <= ovf | step_ovf;
                    if (remaining != '0) begin
                        acc       <= step_val;
                        remaining <= remaining - ITER_W'(1);
                    end else begin
                        y_out <= step_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_affine_cpu.sv
// Scoreboard bench for iter_affine_cpu: a driver pushes model results, a monitor pops them on out_valid.
// Honours ITER_AFFINE_SAT_EN in the reference model so both builds can be checked.
module tb_iter_affine_cpu;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 32;
    localparam int K_W    = 8;
    localparam int ITER_W = 4;

    typedef struct {
        longint y;
        bit     ovf;
        int     acc_cyc;
        int     iter;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     out_ready = 1'b0;
    logic                     in_ready;
    logic                     out_valid;
    logic                     ovf;
    logic signed [IN_W-1:0]   x_in = '0;
    logic signed [K_W-1:0]    add_k = '0;
    logic signed [K_W-1:0]    mul_k = '0;
    logic signed [K_W-1:0]    sub_k = '0;
    logic        [ITER_W-1:0] iter_in = '0;
    logic signed [OUT_W-1:0]  y_out;

    exp_t   sb[$];
    exp_t   mon_e;
    int     checks = 0;
    int     passed = 0;
    int     cycle = 0;
    int     bp_mode = 0;
    bit     seen = 1'b0;
    bit     prev_hs = 1'b0;
    longint held_y = 0;
    bit     held_o = 1'b0;

    iter_affine_cpu #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .K_W   (K_W),
        .ITER_W(ITER_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .add_k    (add_k),
        .mul_k    (mul_k),
        .sub_k    (sub_k),
        .iter_in  (iter_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out    (y_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Consumer backpressure: 0 = always ready, 1 = random, otherwise stalled.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check_output(input string name, input longint got, input longint exp);
        checks++;
        if (got == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic report_fail(input string name);
        checks++;
        $display("[TB] FAIL %s: got timeout, expected completion", name);
    endtask

    function automatic longint fit(input longint v, inout bit o);
        longint maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
        longint minv = -(longint'(1) <<< (OUT_W - 1));
        longint r = v;
        if (v > maxv || v < minv) begin
            o = 1'b1;
`ifdef ITER_AFFINE_SAT_EN
            r = (v > maxv) ? maxv : minv;
`else
            r = v & ((longint'(1) <<< OUT_W) - 1);
            if (r > maxv) r = r - (longint'(1) <<< OUT_W);
`endif
        end
        return r;
    endfunction

    function automatic void ref_model(input longint x, input longint a, input longint m,
                                      input longint s, input int iter,
                                      output longint y, output bit o);
        longint v = x;
        o = 1'b0;
        for (int p = 0; p <= iter; p++) begin
            v = fit(v + a, o);
            v = fit(v * m, o);
            v = fit(v - s, o);
        end
        y = v;
    endfunction

    // Present a transaction, scrambling inputs while the DUT is busy; returns the pre-accept cycle.
    task automatic apply_stimulus(input longint x, input longint a, input longint m, input longint s,
                                  input int iter, input bit push, input bit use_exp,
                                  input longint ey, input bit eo, output int acc_cyc);
        bit     rdy;
        int     tries = 0;
        exp_t   e;
        longint my;
        bit     mo;
        acc_cyc = -1;
        while (1) begin
            @(negedge clk);
            rdy = in_ready;
            if (rdy) begin
                in_valid = 1'b1;
                x_in     = IN_W'(x);
                add_k    = K_W'(a);
                mul_k    = K_W'(m);
                sub_k    = K_W'(s);
                iter_in  = ITER_W'(iter);
                acc_cyc  = cycle;
            end else begin
                in_valid = 1'($urandom);
                x_in     = IN_W'($urandom);
                add_k    = K_W'($urandom);
                mul_k    = K_W'($urandom);
                sub_k    = K_W'($urandom);
                iter_in  = ITER_W'($urandom);
            end
            @(posedge clk);
            if (rdy) break;
            tries++;
            if (tries > 300) begin
                report_fail("accept_timeout");
                return;
            end
        end
        ref_model(x, a, m, s, iter, my, mo);
        e.y       = use_exp ? ey : my;
        e.ovf     = use_exp ? eo : mo;
        e.acc_cyc = acc_cyc;
        e.iter    = iter;
        if (push) sb.push_back(e);
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = IN_W'($urandom);
        add_k    = K_W'($urandom);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (!(sb.size() == 0 && in_ready === 1'b1)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                report_fail("drain_timeout");
                sb.delete();
                return;
            end
        end
    endtask

    // Monitor: pops on the first out_valid cycle, then checks the held output stays put.
    always @(negedge clk) begin
        if (prev_hs) begin
            check_output("release_out_valid", longint'(out_valid), 0);
            check_output("release_in_ready", longint'(in_ready), 1);
        end
        prev_hs = 1'b0;
        if (out_valid === 1'b1) begin
            check_output("busy_in_ready", longint'(in_ready), 0);
            if (!seen) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_output: got y_out %0d, expected no output", y_out);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("y_out", longint'(y_out), mon_e.y);
                    check_output("ovf", longint'(ovf), longint'(mon_e.ovf));
                    check_output("latency", longint'(cycle - mon_e.acc_cyc - 1),
                                 longint'(3 * (mon_e.iter + 1)));
                end
                held_y = y_out;
                held_o = ovf;
                seen   = 1'b1;
            end else begin
                check_output("hold_y_out", longint'(y_out), held_y);
                check_output("hold_ovf", longint'(ovf), longint'(held_o));
            end
            if (out_ready === 1'b1) begin
                prev_hs = 1'b1;
                seen    = 1'b0;
            end
        end
    end

    initial begin : main
        int                     ac;
        int                     prev_ac;
        int                     n;
        int                     it;
        longint                 ey;
        logic signed [IN_W-1:0] rx;
        logic signed [K_W-1:0]  ra;
        logic signed [K_W-1:0]  rm;
        logic signed [K_W-1:0]  rs;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_output("reset_in_ready", longint'(in_ready), 1);
        check_output("reset_out_valid", longint'(out_valid), 0);
        check_output("reset_y_out", longint'(y_out), 0);
        check_output("reset_ovf", longint'(ovf), 0);

        bp_mode = 0;
        apply_stimulus(10, 5, 3, 7, 0, 1'b1, 1'b1, 38, 1'b0, ac);
        apply_stimulus(-4, 5, 3, 7, 0, 1'b1, 1'b1, -4, 1'b0, ac);
        apply_stimulus(10, 5, 3, 7, 1, 1'b1, 1'b1, 122, 1'b0, ac);
`ifdef ITER_AFFINE_SAT_EN
        ey = 2147483640;
`else
        ey = -1589901579;
`endif
        apply_stimulus(32767, 5, 127, 7, 2, 1'b1, 1'b1, ey, 1'b1, ac);
        idle_inputs();
        wait_drain(200);

        // Stalled consumer with a competing in_valid held high throughout.
        bp_mode = 2;
        apply_stimulus(1234, -3, 2, 9, 1, 1'b1, 1'b0, 0, 1'b0, ac);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_in     = IN_W'($urandom);
            mul_k    = K_W'($urandom);
            n++;
        end
        if (n >= 50) report_fail("hold_wait");
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_in     = IN_W'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        bp_mode  = 0;
        wait_drain(50);

        // Reset while the DUT is in its multiply step aborts the transaction silently.
        apply_stimulus(77, 5, 3, 7, 3, 1'b0, 1'b0, 0, 1'b0, ac);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_in_ready", longint'(in_ready), 1);
        check_output("midrst_out_valid", longint'(out_valid), 0);
        check_output("midrst_y_out", longint'(y_out), 0);
        check_output("midrst_ovf", longint'(ovf), 0);
        rst = 1'b0;
        apply_stimulus(10, 5, 3, 7, 0, 1'b1, 1'b0, 0, 1'b0, ac);
        idle_inputs();
        wait_drain(50);

        // Back-to-back single-pass stream with the consumer always ready.
        prev_ac = -1;
        for (int i = 0; i < 8; i++) begin
            rx = IN_W'($urandom);
            ra = K_W'($urandom);
            rm = K_W'($urandom);
            rs = K_W'($urandom);
            apply_stimulus(rx, ra, rm, rs, 0, 1'b1, 1'b0, 0, 1'b0, ac);
            if (prev_ac >= 0) check_output("b2b_spacing", longint'(ac - prev_ac), 5);
            prev_ac = ac;
        end
        idle_inputs();
        wait_drain(100);

        bp_mode = 1;
        for (int i = 0; i < 30; i++) begin
            rx = IN_W'($urandom);
            ra = K_W'($urandom);
            rm = K_W'($urandom);
            rs = K_W'($urandom);
            it = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
            apply_stimulus(rx, ra, rm, rs, it, 1'b1, 1'b0, 0, 1'b0, ac);
        end
        idle_inputs();
        wait_drain(2000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
